// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage with a PC register, IF/ID pipeline registers and optional stall/flush counters.
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   PCWrite            - 1 holds the PC (stall)
//   IFIDWrite          - 1 holds the IF/ID registers
//   IFFlush, JumpAddr  - redirect fetch to word-aligned JumpAddr and squash IF/ID
//   IM_Addr, IM_Instr  - instruction memory address (the PC) and returned instruction
//   ID_Instr, ID_PC, ID_Valid - IF/ID registers: instruction, its PC+4, valid flag
//   StallCnt, FlushCnt - performance counters, present only with IF_PERF_CNT_EN defined, else tied to 0
module if_fetch_stage #(
  parameter int bit_size = 32,
  parameter logic [bit_size-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCWrite,
  input  logic                IFIDWrite,
  input  logic                IFFlush,
  input  logic [bit_size-1:0] JumpAddr,
  output logic [bit_size-1:0] IM_Addr,
  input  logic [bit_size-1:0] IM_Instr,
  output logic [bit_size-1:0] ID_Instr,
  output logic [bit_size-1:0] ID_PC,
  output logic                ID_Valid,
  output logic [bit_size-1:0] StallCnt,
  output logic [bit_size-1:0] FlushCnt
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam logic [bit_size-1:0] pc_step = bit_size'(4);
  state_t              state_q, state_d;
  logic [bit_size-1:0] pc_q, pc_d, pc_plus4;
  logic [bit_size-1:0] id_instr_q, id_instr_d;
  logic [bit_size-1:0] id_pc_q, id_pc_d;
  logic                id_valid_q, id_valid_d;
  logic                run;
  logic                unused_jump_lsbs;
  assign unused_jump_lsbs = ^JumpAddr[1:0];
  assign run      = (state_q == RUN);
  assign pc_plus4 = pc_q + pc_step;
  assign IM_Addr  = pc_q;
  assign ID_Instr = id_instr_q;
  assign ID_PC    = id_pc_q;
  assign ID_Valid = id_valid_q;
  // BOOT spends exactly one cycle with the pipeline empty so the first fetch sees a settled PC.
  always_comb begin
    state_d    = RUN;
    pc_d       = !run ? pc_q : IFFlush ? {JumpAddr[bit_size-1:2], 2'b00} : PCWrite ? pc_q : pc_plus4;
    id_instr_d = !run ? '0 : IFFlush ? '0 : IFIDWrite ? id_instr_q : IM_Instr;
    id_pc_d    = !run ? '0 : (IFFlush || IFIDWrite) ? id_pc_q : pc_plus4;
    id_valid_d = !run ? 1'b0 : IFFlush ? 1'b0 : IFIDWrite ? id_valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= PC_RESET;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  localparam logic [bit_size-1:0] cnt_inc = bit_size'(1);
  logic [bit_size-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = (run && PCWrite && !IFFlush && !(&stall_cnt_q)) ? stall_cnt_q + cnt_inc : stall_cnt_q;
    flush_cnt_d = (run && IFFlush && !(&flush_cnt_q)) ? flush_cnt_q + cnt_inc : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter bit_size, default 32, meaning the width of the PC, instruction and counter datapaths.
REQ-002 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port PCWrite  input  1  high = hold PC (stall request from the hazard detection unit).
REQ-006 SHALL have port IFIDWrite  input  1  high = hold the IF/ID registers.
REQ-007 SHALL have port IFFlush  input  1  high = taken jump/branch in EX; redirect fetch and squash IF/ID.
REQ-008 SHALL have port JumpAddr  input  bit_size  redirect target, valid when IFFlush=1.
REQ-009 SHALL have port IM_Addr  output  bit_size  instruction memory address, equal to the current PC.
REQ-010 SHALL have port IM_Instr  input  bit_size  instruction read combinationally from IM_Addr in the same cycle.
REQ-011 SHALL have port ID_Instr  output  bit_size  registered instruction for the ID stage.
REQ-012 SHALL have port ID_PC  output  bit_size  registered PC+4 of ID_Instr.
REQ-013 SHALL have port ID_Valid  output  1  high = ID_Instr is a real instruction, low = bubble.
REQ-014 SHALL have port StallCnt  output  bit_size  count of stalled cycles.
REQ-015 SHALL have port FlushCnt  output  bit_size  count of flush cycles.

Function
REQ-016 SHALL implement a two-state FSM: BOOT and RUN.
REQ-017 SHALL enter BOOT on reset and move to RUN unconditionally on the next edge.
REQ-018 In BOOT: SHALL hold the PC, hold ID_Instr=0, ID_PC=0 and ID_Valid=0, and ignore PCWrite, IFIDWrite and IFFlush.
REQ-019 Priority in RUN SHALL be: IFFlush, then PCWrite/IFIDWrite, then normal advance.
REQ-020 In RUN with IFFlush=1: PC SHALL take {JumpAddr[bit_size-1:2],2'b00}, ID_Instr SHALL take 0 (nop), ID_Valid SHALL take 0 and ID_PC SHALL hold; PCWrite and IFIDWrite are ignored.
REQ-021 In RUN with IFFlush=0: PC SHALL hold when PCWrite=1 and otherwise take PC+4, wrapping modulo 2^bit_size.
REQ-022 In RUN with IFFlush=0 and IFIDWrite=1: ID_Instr, ID_PC and ID_Valid SHALL hold.
REQ-023 In RUN with IFFlush=0 and IFIDWrite=0: ID_Instr SHALL take IM_Instr, ID_PC SHALL take PC+4 (wrapped) and ID_Valid SHALL take 1.
REQ-024 PCWrite and IFIDWrite SHALL act independently; no cross-check between them.
REQ-025 Latency SHALL be one cycle from IM_Addr presentation to ID_Instr update.
REQ-026 A redirect SHALL take effect on IM_Addr in the cycle after IFFlush is sampled.
REQ-027 IM_Addr SHALL be driven directly from the PC register, with no combinational path from any input.

Reset
REQ-028 On rst=1 at a rising edge: PC SHALL take PC_RESET, ID_Instr, ID_PC and ID_Valid SHALL take 0, the FSM SHALL take BOOT, and both counters SHALL take 0.
REQ-029 rst SHALL override every other input, including mid-stall and mid-flush.

Configuration
REQ-030 Macro IF_PERF_CNT_EN SHALL control the performance counters.
REQ-031 With IF_PERF_CNT_EN defined:
- StallCnt SHALL increment in RUN cycles with PCWrite=1 and IFFlush=0.
- FlushCnt SHALL increment in RUN cycles with IFFlush=1.
- Both SHALL saturate at all-ones.
REQ-032 Without IF_PERF_CNT_EN: StallCnt and FlushCnt ports SHALL exist and SHALL be tied to constant 0, with no counter registers.

Verification
REQ-033 Reset, then idle with IM_Instr=32'hAAAA0000+IM_Addr -> cycle1 BOOT, PC=0 and ID_Valid=0; then IM_Addr=0,4,8; ID_Instr=32'hAAAA0000 with ID_PC=4 and ID_Valid=1 one cycle after RUN entry.
REQ-034 PCWrite=1 and IFIDWrite=1 for 2 cycles at PC=8 -> IM_Addr stays 8 and ID regs hold; with the macro, StallCnt=2.
REQ-035 IFFlush=1 and JumpAddr=32'h0000_0103 coinciding with PCWrite=1 -> next cycle IM_Addr=32'h100, ID_Instr=0 and ID_Valid=0; with the macro, FlushCnt=1 and StallCnt unchanged.
REQ-036 PC forced to 32'hFFFF_FFFC by a jump, then advance -> IM_Addr=0 and ID_PC=0.
REQ-037 rst=1 asserted during a stall with PC=32'h40 -> next cycle PC=PC_RESET, ID_Valid=0, FSM=BOOT and counters=0.
REQ-038 Build without IF_PERF_CNT_EN and run REQ-034 -> StallCnt=0 and FlushCnt=0 at all times.
